// File: rtl/cla_arb_pkg.sv
// Shared types and helpers for the cla_add_arbiter slice.
package cla_arb_pkg;

  localparam int CLA_WIDTH = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic [CLA_WIDTH-1:0] operand_t;

  // Next round-robin start position after granting idx out of n requesters.
  function automatic int rr_advance(input int idx, input int n);
    int nxt;
    nxt = idx + 1;
    if (nxt >= n) begin
      nxt = 0;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder_15bit.sv
// 15-bit carry-lookahead adder: every carry is a flat sum-of-products of
// generate/propagate terms, so no carry ripples from bit to bit.
module carry_lookahead_adder_15bit
  import cla_arb_pkg::*;
(
  input  operand_t a,
  input  operand_t b,
  input  logic     cin,
  output operand_t sum,
  output logic     cout
);

  operand_t              gen_s;
  operand_t              prop_s;
  logic [CLA_WIDTH:0]    carry_s;
  logic                  acc_s;
  logic                  pp_s;

  assign gen_s  = a & b;
  assign prop_s = a ^ b;

  // carry_s[i] = carry into bit i, expanded over all lower generate terms.
  always_comb begin
    carry_s    = '0;
    acc_s      = 1'b0;
    pp_s       = 1'b1;
    carry_s[0] = cin;
    for (int i = 1; i <= CLA_WIDTH; i++) begin
      acc_s = 1'b0;
      pp_s  = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        acc_s = acc_s | (pp_s & gen_s[j]);
        pp_s  = pp_s & prop_s[j];
      end
      carry_s[i] = acc_s | (pp_s & cin);
    end
  end

  assign sum  = prop_s ^ carry_s[CLA_WIDTH-1:0];
  assign cout = carry_s[CLA_WIDTH];

endmodule

// File: rtl/cla_rr_grant.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr.
module cla_rr_grant #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  int pos_v;

  // Scan from the farthest offset down so the closest valid to rr_ptr wins last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    pos_v     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos_v = int'(rr_ptr) + k;
      if (pos_v >= N_REQ) begin
        pos_v = pos_v - N_REQ;
      end else begin
        pos_v = pos_v;
      end
      if (valid[IDX_W'(pos_v)]) begin
        grant                 = '0;
        grant[IDX_W'(pos_v)]  = 1'b1;
        grant_idx             = IDX_W'(pos_v);
        grant_vld             = 1'b1;
      end else begin
        grant_vld = grant_vld;
      end
    end
  end

endmodule

// File: rtl/cla_add_arbiter.sv
// Round-robin arbiter sharing one 15-bit CLA between N_REQ requesters.
// Define CLA_ARB_STATS_EN to add per-requester 16-bit grant counters (o_grant_cnt).
module cla_add_arbiter
  import cla_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 15,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*WIDTH-1:0] i_req_add1,
  input  logic [N_REQ*WIDTH-1:0] i_req_add2,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic                   o_rsp_valid,
  output logic [IDX_W-1:0]       o_rsp_id,
  output logic [WIDTH:0]         o_rsp_result,
`ifdef CLA_ARB_STATS_EN
  output logic [N_REQ*16-1:0]    o_grant_cnt,
`endif
  input  logic                   i_rsp_ready
);

  if (WIDTH != CLA_WIDTH) begin : g_bad_width
    $error("cla_add_arbiter: WIDTH must equal the CLA width (15)");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("cla_add_arbiter: N_REQ must be in 2..8");
  end

  state_t             state_r;
  state_t             state_nxt_s;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   id_r;
  logic [IDX_W-1:0]   rsp_id_r;
  logic [IDX_W-1:0]   grant_idx_s;
  logic [N_REQ-1:0]   grant_s;
  logic               grant_vld_s;
  logic               transfer_s;
  operand_t           add1_r;
  operand_t           add2_r;
  operand_t           sel_add1_s;
  operand_t           sel_add2_s;
  operand_t           sum_s;
  logic               cout_s;
  logic               rsp_valid_r;
  logic [WIDTH:0]     rsp_result_r;

  cla_rr_grant #(.N_REQ(N_REQ)) u_grant (
    .valid     (i_req_valid),
    .rr_ptr    (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_vld (grant_vld_s)
  );

  carry_lookahead_adder_15bit u_cla (
    .a    (add1_r),
    .b    (add2_r),
    .cin  (1'b0),
    .sum  (sum_s),
    .cout (cout_s)
  );

  assign transfer_s = (state_r == IDLE) && grant_vld_s;

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_add1_s = '0;
    sel_add2_s = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (grant_s[r]) begin
        sel_add1_s = i_req_add1[r*WIDTH +: WIDTH];
        sel_add2_s = i_req_add2[r*WIDTH +: WIDTH];
      end else begin
        sel_add1_s = sel_add1_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (transfer_s) begin
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: state_nxt_s = RESP;
      RESP: begin
        if (i_rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: requests are accepted only while idle.
  always_comb begin
    o_req_ready = '0;
    case (state_r)
      IDLE:    o_req_ready = grant_s;
      default: o_req_ready = '0;
    endcase
  end

  // Datapath: operand capture, result capture, response handshake.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rr_ptr_r     <= '0;
      id_r         <= '0;
      add1_r       <= '0;
      add2_r       <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= '0;
      rsp_result_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (transfer_s) begin
            add1_r   <= sel_add1_s;
            add2_r   <= sel_add2_s;
            id_r     <= grant_idx_s;
            rr_ptr_r <= IDX_W'(rr_advance(int'(grant_idx_s), N_REQ));
          end
        end
        CALC: begin
          rsp_result_r <= {cout_s, sum_s};
          rsp_id_r     <= id_r;
          rsp_valid_r  <= 1'b1;
        end
        RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_r <= 1'b0;
          end
        end
        default: rsp_valid_r <= 1'b0;
      endcase
    end
  end

  assign o_rsp_valid  = rsp_valid_r;
  assign o_rsp_id     = rsp_id_r;
  assign o_rsp_result = rsp_result_r;

`ifdef CLA_ARB_STATS_EN
  logic [15:0] grant_cnt_r [N_REQ];

  // Per-requester grant counters; natural 16-bit wrap.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int r = 0; r < N_REQ; r++) begin
        grant_cnt_r[r] <= 16'd0;
      end
    end else begin
      for (int r = 0; r < N_REQ; r++) begin
        if (transfer_s && grant_s[r]) begin
          grant_cnt_r[r] <= grant_cnt_r[r] + 16'd1;
        end
      end
    end
  end

  for (genvar r = 0; r < N_REQ; r++) begin : g_cnt_out
    assign o_grant_cnt[r*16 +: 16] = grant_cnt_r[r];
  end
`endif

endmodule

// File: tb/tb_cla_add_arbiter.sv
// Self-checking bench for cla_add_arbiter: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_cla_add_arbiter;

  localparam int N  = 4;
  localparam int W  = 15;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*W-1:0]    add1;
  logic [N*W-1:0]    add2;
  logic [N-1:0]      req_ready;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [W:0]        rsp_result;
  logic              rsp_ready;
`ifdef CLA_ARB_STATS_EN
  logic [N*16-1:0]   grant_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the adder, and what it must eventually answer.
  int          m_ptr;
  int          m_phase;   // 0 free, 1 computing, 2 answer outstanding
  int          m_id;
  logic [W:0]  m_result;
  int          m_cnt [N];
  logic [N-1:0] obs_ready;

  always #5 clk = ~clk;

  cla_add_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .i_req_add1   (add1),
    .i_req_add2   (add2),
    .o_req_ready  (req_ready),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_id     (rsp_id),
    .o_rsp_result (rsp_result),
`ifdef CLA_ARB_STATS_EN
    .o_grant_cnt  (grant_cnt),
`endif
    .i_rsp_ready  (rsp_ready)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    add1[r*W +: W] = a;
    add2[r*W +: W] = b;
  endtask

  // One clock: inputs already set at the negedge; check, clock, advance model.
  task automatic step(input logic rst, input logic rdy);
    int g;
    logic [N-1:0] exp_ready;
    rst_n     = rst;
    rsp_ready = rdy;
    #1;
    g = pick(req_valid, m_ptr);
    exp_ready = '0;
    if (m_phase == 0 && g >= 0) exp_ready[g] = 1'b1;
    obs_ready = req_ready;
    check_val("req_ready", 32'(req_ready), 32'(exp_ready));
    check_val("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
    if (m_phase == 2) begin
      check_val("rsp_id", 32'(rsp_id), 32'(m_id));
      check_val("rsp_result", 32'(rsp_result), 32'(m_result));
    end
    @(posedge clk);
    if (!rst) begin
      m_ptr = 0;
      m_phase = 0;
      for (int r = 0; r < N; r++) m_cnt[r] = 0;
    end else begin
      case (m_phase)
        0: if (g >= 0) begin
             m_id     = g;
             m_result = {1'b0, add1[g*W +: W]} + {1'b0, add2[g*W +: W]};
             m_ptr    = (g + 1) % N;
             m_phase  = 1;
             m_cnt[g] = m_cnt[g] + 1;
           end
        1: m_phase = 2;
        2: if (rdy) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
    @(negedge clk);
  endtask

  // Single request from r: grant cycle, compute cycle; leaves the answer in RESP.
  task automatic one_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid = '0;
    req_valid[r] = 1'b1;
    set_req(r, a, b);
    step(1'b1, 1'b1);
    check_val("grant_onehot", 32'(obs_ready), 32'(1 << r));
    req_valid = '0;
    step(1'b1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; add1 = '0; add2 = '0; rsp_ready = 1'b0;
    m_ptr = 0; m_phase = 0; m_id = 0; m_result = '0;
    for (int r = 0; r < N; r++) m_cnt[r] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rst_ready", 32'(req_ready), 32'h0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_val("rst_rsp_id", 32'(rsp_id), 32'h0);
    check_val("rst_rsp_result", 32'(rsp_result), 32'h0);
    @(negedge clk);

    // Basic add from r0
    one_req(0, 15'h0003, 15'h0004);
    check_val("t1_valid", 32'(rsp_valid), 32'h1);
    check_val("t1_id", 32'(rsp_id), 32'h0);
    check_val("t1_result", 32'(rsp_result), 32'h0007);
    step(1'b1, 1'b1);

    // Carry into the top bit from r2, then worst case from r3
    one_req(2, 15'h7FFF, 15'h0001);
    check_val("t2_id", 32'(rsp_id), 32'h2);
    check_val("t2_result", 32'(rsp_result), 32'h8000);
    step(1'b1, 1'b1);
    one_req(3, 15'h7FFF, 15'h7FFF);
    check_val("t2_worst", 32'(rsp_result), 32'hFFFE);
    step(1'b1, 1'b1);

    // All requesters valid: rotation 0,1,2,3,0
    for (int r = 0; r < N; r++) set_req(r, W'(16'h0100 * (r + 1)), W'(r));
    for (int i = 0; i < 5; i++) begin
      req_valid = 4'b1111;
      step(1'b1, 1'b1);
      check_val("t3_order", 32'(obs_ready), 32'(1 << (i % N)));
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
    end

    // Back-pressure: answer held for 10 cycles, no new grants meanwhile
    one_req(1, 15'h1234, 15'h0F0F);
    req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      check_val("t4_hold_result", 32'(rsp_result), 32'h2143);
    end
    step(1'b1, 1'b1);
    check_val("t4_accepted", 32'(rsp_valid), 32'h0);

    // Reset during CALC aborts the request and restarts priority at r0
    step(1'b1, 1'b1);
    req_valid = '0;
    step(1'b0, 1'b1);
    check_val("t5_valid", 32'(rsp_valid), 32'h0);
    check_val("t5_result", 32'(rsp_result), 32'h0);
    req_valid = 4'b1111;
    step(1'b1, 1'b1);
    check_val("t5_ptr", 32'(obs_ready), 32'h1);
    req_valid = '0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      req_valid = N'($urandom);
      for (int r = 0; r < N; r++) set_req(r, W'($urandom), W'($urandom));
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0));
    end

`ifdef CLA_ARB_STATS_EN
    req_valid = '0;
    step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      one_req(1, W'(i), 15'h0001);
      step(1'b1, 1'b1);
    end
    check_val("t6_cnt1", 32'(grant_cnt[16 +: 16]), 32'd5);
    check_val("t6_cnt0", 32'(grant_cnt[0 +: 16]), 32'd0);
    check_val("t6_cnt2", 32'(grant_cnt[32 +: 16]), 32'd0);
    check_val("t6_cnt3", 32'(grant_cnt[48 +: 16]), 32'd0);
    for (int r = 0; r < N; r++) check_val("t6_model_cnt", 32'(grant_cnt[r*16 +: 16]), 32'(m_cnt[r]));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
